floating_subtractor_seq: RTL

- Multi-cycle IEEE-754 single-precision subtractor; computes out = a - b.
- Inverse-direction companion to the team's combinational single-precision adder, and uses the same field split and sign-magnitude add.
- Iterative shifter: one alignment or normalization bit per cycle, so there is no barrel shifter.
- Valid/ready handshake on input and output; sits in the FP datapath where area matters more than latency.

---
 rtl/fp_pkg.sv | 41 ++++
 rtl/fp_norm_shifter.sv | 17 +
 rtl/floating_subtractor_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision field definitions, FSM state encoding and result packing
// for the sequential FP subtractor.
package fp_pkg;

   localparam int unsigned FP_BIAS    = 127;
   localparam int unsigned FP_EXP_W   = 8;
   localparam int unsigned FP_MAN_W   = 23;
   localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StAlign = 3'd1,
      StAdd   = 3'd2,
      StNorm  = 3'd3,
      StRound = 3'd4,
      StDone  = 3'd5
   } fp_state_e;

   typedef struct packed {
      logic                sign;
      logic [FP_EXP_W-1:0] exp;
      logic [FP_MAN_W-1:0] man;
   } fp32_t;

   // man carries the hidden bit in [23]; a clear hidden bit means a zero magnitude.
   function automatic logic [31:0] fp_pack(input logic sign, input logic signed [9:0] exp,
                                           input logic [23:0] man);
      logic [31:0] res;
      if (!man[23]) begin
         res = 32'h0;
      end else if (exp >= 10'sd255) begin
         res = {sign, FP_EXP_MAX, 23'h0};
      end else if (exp <= 10'sd0) begin
         res = {sign, 31'h0};
      end else begin
         res = {sign, exp[7:0], man[22:0]};
      end
      return res;
   endfunction

endpackage

// File: rtl/fp_norm_shifter.sv
// Single-bit mantissa shifter: right shift folds the two low bits into sticky,
// left shift fills with zero.
module fp_norm_shifter (
   input  logic [27:0] data_i,
   input  logic        left_i,
   output logic [27:0] data_o
);

   always_comb begin
      if (left_i) begin
         data_o = {data_i[26:0], 1'b0};
      end else begin
         data_o = {1'b0, data_i[27:2], data_i[1] | data_i[0]};
      end
   end

endmodule

// File: rtl/floating_subtractor_seq.sv
// Multi-cycle IEEE-754 single subtractor (out = a - b), one shift per cycle.
// Define FP_ROUND_NEAREST_EN to add a round-to-nearest-even stage before DONE.
module floating_subtractor_seq
   import fp_pkg::*;
#(
   parameter int unsigned ALIGN_CAP = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out
);

   localparam logic [7:0] CapW = 8'(ALIGN_CAP);

   fp_state_e          state_q, state_d;
   logic               sign_l_q, sign_l_d;
   logic               sign_s_q, sign_s_d;
   logic signed [9:0]  exp_q, exp_d;
   logic [26:0]        man_l_q, man_l_d;
   logic [26:0]        man_s_q, man_s_d;
   logic [7:0]         cnt_q, cnt_d;
   logic               collapse_q, collapse_d;
   logic [27:0]        sum_q, sum_d;
   logic               res_sign_q, res_sign_d;
   logic [31:0]        out_q, out_d;

   fp32_t              op_a, op_b;
   logic [26:0]        man_a, man_b;
   logic               a_big;
   logic [7:0]         exp_diff;
   logic [27:0]        shf_in, shf_out;
   logic               shf_left;
   logic [27:0]        l_ext, s_ext;

`ifdef FP_ROUND_NEAREST_EN
   logic               round_up;
   logic [24:0]        man_rnd;
`endif

   // Subtraction is addition with the subtrahend's sign flipped.
   assign op_a  = a;
   assign op_b  = {~b[31], b[30:0]};
   assign man_a = (op_a.exp == 8'h00) ? 27'h0 : {1'b1, op_a.man, 3'b000};
   assign man_b = (op_b.exp == 8'h00) ? 27'h0 : {1'b1, op_b.man, 3'b000};
   assign a_big = (op_a.exp >= op_b.exp);
   assign exp_diff = a_big ? (op_a.exp - op_b.exp) : (op_b.exp - op_a.exp);

   assign l_ext = {1'b0, man_l_q};
   assign s_ext = {1'b0, man_s_q};

   fp_norm_shifter u_shifter (
      .data_i (shf_in),
      .left_i (shf_left),
      .data_o (shf_out)
   );

   always_comb begin
      state_d    = state_q;
      sign_l_d   = sign_l_q;
      sign_s_d   = sign_s_q;
      exp_d      = exp_q;
      man_l_d    = man_l_q;
      man_s_d    = man_s_q;
      cnt_d      = cnt_q;
      collapse_d = collapse_q;
      sum_d      = sum_q;
      res_sign_d = res_sign_q;
      out_d      = out_q;
      shf_in     = sum_q;
      shf_left   = 1'b0;
`ifdef FP_ROUND_NEAREST_EN
      round_up   = 1'b0;
      man_rnd    = 25'h0;
`endif

      case (state_q)
         StIdle: begin
            if (in_valid) begin
               sign_l_d   = a_big ? op_a.sign : op_b.sign;
               sign_s_d   = a_big ? op_b.sign : op_a.sign;
               man_l_d    = a_big ? man_a : man_b;
               man_s_d    = a_big ? man_b : man_a;
               exp_d      = {2'b00, (a_big ? op_a.exp : op_b.exp)};
               cnt_d      = (exp_diff > CapW) ? CapW : exp_diff;
               collapse_d = (exp_diff > CapW);
               state_d    = (exp_diff != 8'h00) ? StAlign : StAdd;
            end
         end

         StAlign: begin
            shf_in   = {1'b0, man_s_q};
            shf_left = 1'b0;
            man_s_d  = shf_out[26:0];
            cnt_d    = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               state_d = StAdd;
               if (collapse_q) begin
                  man_s_d = {26'h0, |shf_out[26:0]};
               end
            end
         end

         StAdd: begin
            if (sign_l_q == sign_s_q) begin
               sum_d      = l_ext + s_ext;
               res_sign_d = sign_l_q;
            end else if (man_l_q >= man_s_q) begin
               sum_d      = l_ext - s_ext;
               res_sign_d = sign_l_q;
            end else begin
               sum_d      = s_ext - l_ext;
               res_sign_d = sign_s_q;
            end
            state_d = StNorm;
         end

         StNorm: begin
            shf_in   = sum_q;
            shf_left = ~sum_q[27];
            if (sum_q == 28'h0 || sum_q[27] || sum_q[26]) begin
               if (sum_q[27]) begin
                  sum_d = shf_out;
                  exp_d = exp_q + 10'sd1;
               end
`ifdef FP_ROUND_NEAREST_EN
               state_d = StRound;
`else
               state_d = StDone;
               out_d   = fp_pack(res_sign_q, exp_d, sum_d[26:3]);
`endif
            end else begin
               sum_d = shf_out;
               exp_d = exp_q - 10'sd1;
            end
         end

`ifdef FP_ROUND_NEAREST_EN
         StRound: begin
            round_up = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
            man_rnd  = {1'b0, sum_q[26:3]} + {24'h0, round_up};
            if (man_rnd[24]) begin
               exp_d = exp_q + 10'sd1;
               out_d = fp_pack(res_sign_q, exp_d, man_rnd[24:1]);
            end else begin
               out_d = fp_pack(res_sign_q, exp_q, man_rnd[23:0]);
            end
            state_d = StDone;
         end
`endif

         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         sign_l_q   <= 1'b0;
         sign_s_q   <= 1'b0;
         exp_q      <= 10'sd0;
         man_l_q    <= 27'h0;
         man_s_q    <= 27'h0;
         cnt_q      <= 8'h0;
         collapse_q <= 1'b0;
         sum_q      <= 28'h0;
         res_sign_q <= 1'b0;
         out_q      <= 32'h0;
      end else begin
         state_q    <= state_d;
         sign_l_q   <= sign_l_d;
         sign_s_q   <= sign_s_d;
         exp_q      <= exp_d;
         man_l_q    <= man_l_d;
         man_s_q    <= man_s_d;
         cnt_q      <= cnt_d;
         collapse_q <= collapse_d;
         sum_q      <= sum_d;
         res_sign_q <= res_sign_d;
         out_q      <= out_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign out       = out_q;

endmodule
